regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with a pending-write scoreboard.
//
// Two writers share one register-file write port:
//   A : pipeline writeback
//   B : multi-cycle functional unit
// The chosen write appears on RegWrite/Rd/WriteData one cycle after the
// transfer. A write to register 0 is accepted but never strobed.
//
// busy[r] is set when a B-bound instruction with destination r issues.
// It clears when B delivers its write to r.
//
// Handshake: a transfer happens on a requester in any cycle where its
// valid and ready are both 1. Ready depends only on the two valids, the
// priority bit and reset, never on the ready of the other side. A
// requester holds valid, rd and data stable until it sees ready. At most
// one transfer happens per cycle.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_rd,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_rd,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  input  logic                 b_issue,
  input  logic [ADDR_W-1:0]    b_issue_rd,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    Rd,
  output logic [DATA_W-1:0]    WriteData,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int NREG = 2**ADDR_W;

  // Which requester wins a contended cycle: 0 = A, 1 = B.
  logic              prio;
  logic              grant_a;
  logic              grant_b;
  logic              contended;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_next;

  // Grant selection; both readies are held low while reset is asserted.
  always_comb begin
    contended = a_valid && b_valid;
    grant_a   = !Rst && a_valid && (!b_valid || !prio);
    grant_b   = !Rst && b_valid && (!a_valid || prio);
    xfer      = grant_a || grant_b;
    sel_rd    = grant_b ? b_rd   : a_rd;
    sel_data  = grant_b ? b_data : a_data;
    a_ready   = grant_a;
    b_ready   = grant_b;
  end

  // Scoreboard next state: apply the clear first so a same-register issue wins.
  always_comb begin
    busy_next = busy;
    if (grant_b && (b_rd != '0)) begin
      busy_next[b_rd] = 1'b0;
    end
    if (b_issue && (b_issue_rd != '0)) begin
      busy_next[b_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Registered write port, priority bit and scoreboard.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prio      <= 1'b0;
      RegWrite  <= 1'b0;
      Rd        <= '0;
      WriteData <= '0;
      busy      <= '0;
    end else begin
      // Hand priority to the loser only when both asked.
      if (contended) begin
        prio <= grant_a;
      end
      RegWrite <= xfer && (sel_rd != '0);
      if (xfer && (sel_rd != '0)) begin
        Rd        <= sel_rd;
        WriteData <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule
